forward_stall_unit: RTL

FORWARD_STALL_UNIT -- requirements
Module: forward_stall_unit

---
 rtl/forward_stall_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/forward_stall_unit.sv
// Forwarding and load-use stall unit for an in-order pipeline.
// Tracks the destination of the instruction in EX and in each post-EX stage,
// picks the nearest forwardable producer for every EX source operand, and
// holds ID while a load it depends on cannot yet deliver its data.
module forward_stall_unit #(
   parameter int REG_W      = 5,
   parameter int NUM_SRC    = 2,
   parameter int FWD_DEPTH  = 2,
   parameter int LOAD_STAGE = 2,
   localparam int SEL_W     = ($clog2(FWD_DEPTH + 1) < 1) ? 1 : $clog2(FWD_DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       arst_n,
   input  logic                       id_valid,
   input  logic [NUM_SRC*REG_W-1:0]   id_rs,
   input  logic [NUM_SRC-1:0]         id_rs_used,
   input  logic [REG_W-1:0]           id_rd,
   input  logic                       id_reg_write,
   input  logic                       id_mem_read,
   input  logic                       pipe_hold,
   input  logic                       ex_flush,
   output logic                       stall_id,
   output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
   output logic [15:0]                stall_count
);

   // Destination record carried by every tracked stage (slot 0 = EX).
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             reg_write;
      logic             mem_read;
   } slot_t;

   localparam slot_t BUBBLE = '0;

   slot_t            slot_q    [FWD_DEPTH+1];
   slot_t            slot_d    [FWD_DEPTH+1];
   logic [REG_W-1:0] ex_rs_q   [NUM_SRC];
   logic [REG_W-1:0] ex_rs_d   [NUM_SRC];
   logic [NUM_SRC-1:0] ex_used_q;
   logic [NUM_SRC-1:0] ex_used_d;
   logic [15:0]      stall_count_q;
   logic [15:0]      stall_count_d;
   logic [NUM_SRC-1:0] load_hit;

   // A slot produces register r only if it is a live writer of a non-zero register.
   function automatic logic writes_reg(input slot_t s, input logic [REG_W-1:0] r);
      return s.valid && s.reg_write && (s.rd == r) && (r != '0);
   endfunction

   // Load-use hazard: the nearest producer of an ID source is a load that will
   // not yet have reached a forwardable stage when the consumer enters EX.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      load_hit = '0;
      stall_id = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         // Walk from the oldest slot towards EX so the nearest writer overrides.
         for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
            if (writes_reg(slot_q[j], id_rs[s*REG_W +: REG_W])) begin
               load_hit[s] = slot_q[j].mem_read && (j + 1 < LOAD_STAGE);
            end
         end
      end
      stall_id = id_valid && |(load_hit & id_rs_used);
   end

   // Operand mux select: nearest producer wins; a not-yet-ready load selects the register file.
   always_comb begin
      fwd_sel = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (ex_used_q[s] && writes_reg(slot_q[k], ex_rs_q[s])) begin
               fwd_sel[s*SEL_W +: SEL_W] = (slot_q[k].mem_read && (k < LOAD_STAGE))
                                           ? '0 : SEL_W'(k);
            end
         end
      end
   end

   // Next-state: advance the tracked stages, inject ID or a bubble, count load-use stalls.
   always_comb begin
      slot_d        = slot_q;
      ex_rs_d       = ex_rs_q;
      ex_used_d     = ex_used_q;
      stall_count_d = stall_count_q;
      if (!pipe_hold) begin
         for (int k = FWD_DEPTH; k >= 1; k--) begin
            slot_d[k] = slot_q[k-1];
         end
         // A flush wins over a stall; both leave a bubble in EX.
         if (stall_id || ex_flush) begin
            slot_d[0] = BUBBLE;
            ex_used_d = '0;
         end else begin
            slot_d[0].valid     = id_valid;
            slot_d[0].rd        = id_rd;
            slot_d[0].reg_write = id_reg_write;
            slot_d[0].mem_read  = id_mem_read;
            for (int s = 0; s < NUM_SRC; s++) begin
               ex_rs_d[s] = id_rs[s*REG_W +: REG_W];
            end
            ex_used_d = id_rs_used;
         end
         if (stall_id && !ex_flush && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
         end
      end else if (ex_flush) begin
         // Frozen pipeline, but the instruction in EX is still killed.
         slot_d[0] = BUBBLE;
         ex_used_d = '0;
      end
   end

   // State registers; reset discards every in-flight record.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         // NOTE: the slot arrays are a handful of pipeline flops, not a RAM, so every entry is reset.
         for (int k = 0; k <= FWD_DEPTH; k++) begin
            slot_q[k] <= BUBBLE;
         end
         for (int s = 0; s < NUM_SRC; s++) begin
            ex_rs_q[s] <= '0;
         end
         ex_used_q     <= '0;
         stall_count_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         slot_q        <= slot_d;
         ex_rs_q       <= ex_rs_d;
         ex_used_q     <= ex_used_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;

endmodule
